// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and constants for the pipeline-advance controller
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } hazard_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_ctrl_mem_req_tracker.sv
// rtl/hazard_stall_ctrl_mem_req_tracker.sv - per-side outstanding request tracker with latched response flag
module mem_req_tracker
    import hazard_stall_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic resp,
    input  logic clr,
    output logic satisfied,
    output logic done
);

    // A response only counts while its request is pending; clr wins so the flag drops on the advance edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= 1'b0;
        end else if (clr) begin
            done <= 1'b0;
        end else if (req && resp) begin
            done <= 1'b1;
        end
    end

    assign satisfied = !req || resp || done;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - global pipeline load/flush controller; optional load-use stall under LOAD_USE_STALL_EN
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 imem_read,
    input  logic                 imem_resp,
    input  logic                 dmem_read,
    input  logic                 dmem_write,
    input  logic                 dmem_resp,
    input  logic                 br_redirect,
    input  logic                 idex_is_load,
    input  logic [4:0]           idex_rd,
    input  logic [4:0]           ifid_rs1,
    input  logic [4:0]           ifid_rs2,
    output logic                 pc_ld,
    output logic                 ifid_ld,
    output logic                 idex_ld,
    output logic                 exmem_ld,
    output logic                 memwb_ld,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count
);

    hazard_state_t state;
    logic d_out, i_sat, d_sat, i_done, d_done, go, load_use, redirect;

    assign d_out = dmem_read || dmem_write;

    mem_req_tracker u_i_trk (
        .clk(clk), .rst(rst), .req(imem_read), .resp(imem_resp), .clr(go),
        .satisfied(i_sat), .done(i_done)
    );

    mem_req_tracker u_d_trk (
        .clk(clk), .rst(rst), .req(d_out), .resp(dmem_resp), .clr(go),
        .satisfied(d_sat), .done(d_done)
    );

    assign go       = i_sat && d_sat;
    assign redirect = go && br_redirect;

`ifdef LOAD_USE_STALL_EN
    assign load_use = go && idex_is_load && (idex_rd != REG_ZERO) && !br_redirect &&
                      ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));
    logic unused_flags;
    assign unused_flags = i_done ^ d_done;
`else
    // Load-use is resolved by MEM->EX forwarding, so the hazard inputs are deliberately dropped.
    assign load_use = 1'b0;
    logic unused_inputs;
    assign unused_inputs = ^{idex_is_load, idex_rd, ifid_rs1, ifid_rs2, i_done, d_done};
`endif

    // Outputs forced low while rst is asserted so no register loads during reset.
    assign pc_ld      = !rst && go && !load_use;
    assign ifid_ld    = !rst && go && !load_use;
    assign idex_ld    = !rst && go;
    assign exmem_ld   = !rst && go;
    assign memwb_ld   = !rst && go;
    assign ifid_flush = !rst && redirect;
    assign idex_flush = !rst && (redirect || load_use);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else if (go) begin
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    if (imem_read && imem_resp) begin
                        state <= WAIT_D;
                    end else if (d_out && dmem_resp) begin
                        state <= WAIT_I;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if ((!go || load_use) && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (redirect && (flush_count != '1)) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - directed self-checking bench for hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    import hazard_stall_ctrl_pkg::*;

    localparam int W = 4;

`ifdef LOAD_USE_STALL_EN
    localparam logic [4:0] LU_LD    = 5'b00111;
    localparam logic [1:0] LU_FL    = 2'b01;
    localparam int         LU_STALL = 2;
`else
    localparam logic [4:0] LU_LD    = 5'b11111;
    localparam logic [1:0] LU_FL    = 2'b00;
    localparam int         LU_STALL = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_read = 0, imem_resp = 0, dmem_read = 0, dmem_write = 0, dmem_resp = 0;
    logic br_redirect = 0, idex_is_load = 0;
    logic [4:0] idex_rd = 0, ifid_rs1 = 0, ifid_rs2 = 0;
    logic pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld, ifid_flush, idex_flush;
    logic [W-1:0] stall_cycles, flush_count;
    logic [4:0] ld;
    logic [1:0] fl;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    hazard_stall_ctrl #(.CNT_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
        .br_redirect(br_redirect), .idex_is_load(idex_is_load), .idex_rd(idex_rd),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
        .pc_ld(pc_ld), .ifid_ld(ifid_ld), .idex_ld(idex_ld), .exmem_ld(exmem_ld),
        .memwb_ld(memwb_ld), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    assign ld = {pc_ld, ifid_ld, idex_ld, exmem_ld, memwb_ld};
    assign fl = {ifid_flush, idex_flush};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem(input logic ir, input logic irs, input logic dr, input logic dw, input logic drs);
        imem_read = ir; imem_resp = irs; dmem_read = dr; dmem_write = dw; dmem_resp = drs;
    endtask

    initial begin
        // reset with a hit pattern on the inputs: outputs must stay low
        mem(1, 1, 1, 0, 1);
        @(negedge clk);
        chk("rst_ld", 32'(ld), 32'h0);
        chk("rst_fl", 32'(fl), 32'h0);
        chk("rst_stall", 32'(stall_cycles), 32'h0);
        chk("rst_flush", 32'(flush_count), 32'h0);
        chk("rst_state", 32'(dut.state), 32'(RUN));
        tick();
        rst = 1'b0;

        // back-to-back I hits
        mem(1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("hit_ld", 32'(ld), 32'h1f);
            tick();
        end
        chk("hit_stall", 32'(stall_cycles), 32'h0);

        // 4-cycle I miss
        mem(1, 0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("imiss_ld", 32'(ld), 32'h0);
            tick();
        end
        imem_resp = 1;
        @(negedge clk);
        chk("imiss_adv", 32'(ld), 32'h1f);
        tick();
        chk("imiss_stall", 32'(stall_cycles), 32'd3);

        // I resp in cycle 2, D resp in cycle 5
        mem(1, 0, 1, 0, 0);
        tick();
        imem_resp = 1;
        @(negedge clk);
        chk("id_c2_ld", 32'(ld), 32'h0);
        tick();
        imem_resp = 0;
        for (int i = 3; i <= 4; i++) begin
            @(negedge clk);
            chk("id_wait_d", 32'(dut.state), 32'(WAIT_D));
            chk("id_wait_ld", 32'(ld), 32'h0);
            tick();
        end
        dmem_resp = 1;
        @(negedge clk);
        chk("id_adv", 32'(ld), 32'h1f);
        tick();
        chk("id_run", 32'(dut.state), 32'(RUN));
        chk("id_stall", 32'(stall_cycles), 32'd7);

        // redirect held across a 3-cycle D-write miss
        mem(0, 0, 0, 1, 0);
        br_redirect = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("br_hold_fl", 32'(fl), 32'h0);
            chk("br_hold_ld", 32'(ld), 32'h0);
            tick();
        end
        dmem_resp = 1;
        @(negedge clk);
        chk("br_fl", 32'(fl), 32'h3);
        chk("br_ld", 32'(ld), 32'h1f);
        tick();
        br_redirect = 0;
        chk("br_count", 32'(flush_count), 32'd1);
        chk("br_stall", 32'(stall_cycles), 32'd9);

        // reach WAIT_I, then reset asynchronously
        mem(1, 0, 1, 0, 1);
        tick();
        chk("wi_state", 32'(dut.state), 32'(WAIT_I));
        mem(0, 0, 0, 0, 0);
        rst = 1;
        @(negedge clk);
        chk("wi_rst_state", 32'(dut.state), 32'(RUN));
        chk("wi_rst_stall", 32'(stall_cycles), 32'h0);
        chk("wi_rst_flush", 32'(flush_count), 32'h0);
        chk("wi_rst_ld", 32'(ld), 32'h0);
        tick();
        rst = 0;
        mem(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("stray_resp_ld", 32'(ld), 32'h1f);
        tick();
        chk("stray_resp_state", 32'(dut.state), 32'(RUN));
        chk("stray_resp_stall", 32'(stall_cycles), 32'h0);
        mem(0, 0, 1, 0, 0);
        @(negedge clk);
        chk("d_flag_cleared", 32'(ld), 32'h0);
        tick();
        dmem_resp = 1;
        @(negedge clk);
        chk("d_adv", 32'(ld), 32'h1f);
        tick();
        mem(0, 0, 0, 0, 0);

        // load-use: lw x5 in ID/EX, consumer of x5 in IF/ID
        idex_is_load = 1; idex_rd = 5'd5; ifid_rs1 = 5'd5; ifid_rs2 = 5'd7;
        @(negedge clk);
        chk("lu_ld", 32'(ld), 32'(LU_LD));
        chk("lu_fl", 32'(fl), 32'(LU_FL));
        tick();
        chk("lu_stall", 32'(stall_cycles), 32'(LU_STALL));
        idex_rd = 5'd0; ifid_rs1 = 5'd0;
        @(negedge clk);
        chk("lu_x0_ld", 32'(ld), 32'h1f);
        tick();
        idex_rd = 5'd5; ifid_rs1 = 5'd1; ifid_rs2 = 5'd5; br_redirect = 1;
        @(negedge clk);
        chk("lu_br_ld", 32'(ld), 32'h1f);
        chk("lu_br_fl", 32'(fl), 32'h3);
        tick();
        chk("lu_br_flush", 32'(flush_count), 32'd1);
        br_redirect = 0; idex_is_load = 0;

        // long I miss saturates the 4-bit stall counter
        mem(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(stall_cycles), 32'hf);
        imem_resp = 1;
        @(negedge clk);
        chk("sat_adv", 32'(ld), 32'h1f);
        tick();
        chk("sat_hold", 32'(stall_cycles), 32'hf);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
